// File: rtl/ctrl_pkg.sv
// Shared encodings for the ctrl_seq control sequencer: state codes, opcodes,
// instruction field widths and the strobe bundle driven toward the datapath.
package ctrl_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned ALU_OP_W = 3;

  localparam logic [OP_W-1:0] OP_LD   = 4'd8;
  localparam logic [OP_W-1:0] OP_ST   = 4'd9;
  localparam logic [OP_W-1:0] OP_LI   = 4'd10;
  localparam logic [OP_W-1:0] OP_JZ   = 4'd11;
  localparam logic [OP_W-1:0] OP_JNZ  = 4'd12;
  localparam logic [OP_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [4:0] {
    StFetch0   = 5'd0,
    StFetch1   = 5'd1,
    StFetch2   = 5'd2,
    StDecode   = 5'd3,
    StA0       = 5'd4,
    StA1       = 5'd5,
    StA2       = 5'd6,
    StL0       = 5'd7,
    StL1       = 5'd8,
    StL2       = 5'd9,
    StS0       = 5'd10,
    StS1       = 5'd11,
    StS2       = 5'd12,
    StI0       = 5'd13,
    StI1       = 5'd14,
    StI2       = 5'd15,
    StJ0       = 5'd16,
    StJ1       = 5'd17,
    StHalted   = 5'd18,
    StStepWait = 5'd19
  } state_e;

  typedef struct packed {
    logic                pc_oe;
    logic                pc_ld;
    logic                pc_inc;
    logic                ir_ld;
    logic                mar_ld;
    logic                mdr_ld_bus;
    logic                mdr_ld_mem;
    logic                mdr_oe;
    logic                mem_rd;
    logic                mem_wr;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_x_ld;
    logic                alu_y_ld;
    logic                alu_oe;
    logic                reg_rd;
    logic                reg_wr;
    logic                halted;
    logic                illegal;
  } strobes_t;

endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer <-> datapath bundle. master = sequencer side, slave = datapath side.
// The step input exists only when CTRL_STEP_EN is defined.
interface ctrl_seq_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REG_AW = 6
);
  import ctrl_pkg::*;

  logic [WIDTH-1:0]    ir;
  logic                mem_ack;
  logic                zero;
`ifdef CTRL_STEP_EN
  logic                step;
`endif
  logic                pc_oe, pc_ld, pc_inc;
  logic                ir_ld;
  logic                mar_ld;
  logic                mdr_ld_bus, mdr_ld_mem, mdr_oe;
  logic                mem_rd, mem_wr;
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_x_ld, alu_y_ld, alu_oe;
  logic [REG_AW-1:0]   reg_addr;
  logic                reg_rd, reg_wr;
  logic                halted;
  logic                illegal;

  modport master (
`ifdef CTRL_STEP_EN
    input  step,
`endif
    input  ir, mem_ack, zero,
    output pc_oe, pc_ld, pc_inc, ir_ld, mar_ld, mdr_ld_bus, mdr_ld_mem, mdr_oe,
    output mem_rd, mem_wr, alu_op, alu_x_ld, alu_y_ld, alu_oe,
    output reg_addr, reg_rd, reg_wr, halted, illegal
  );

  modport slave (
`ifdef CTRL_STEP_EN
    output step,
`endif
    output ir, mem_ack, zero,
    input  pc_oe, pc_ld, pc_inc, ir_ld, mar_ld, mdr_ld_bus, mdr_ld_mem, mdr_oe,
    input  mem_rd, mem_wr, alu_op, alu_x_ld, alu_y_ld, alu_oe,
    input  reg_addr, reg_rd, reg_wr, halted, illegal
  );

endinterface

// File: rtl/ctrl_decode.sv
// Opcode to first-execute-state lookup; flags undefined opcodes (13, 14).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output state_e          first_st_o,
  output logic            illegal_o
);

  always_comb begin
    first_st_o = StFetch0;
    illegal_o  = 1'b0;
    case (op_i)
      OP_LD:          first_st_o = StL0;
      OP_ST:          first_st_o = StS0;
      OP_LI:          first_st_o = StI0;
      OP_JZ, OP_JNZ:  first_st_o = StJ0;
      OP_HALT:        first_st_o = StHalted;
      default: begin
        if (!op_i[OP_W-1]) first_st_o = StA0;
        else               illegal_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multicycle control sequencer: state register, memory handshake waits and Moore strobe decode.
// Define CTRL_STEP_EN to park in StStepWait after each instruction until step = 1.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned REG_AW = 6
) (
  input  logic      clk,
  input  logic      reset,
  ctrl_seq_if.master bus
);

`ifdef CTRL_STEP_EN
  localparam state_e DoneSt = StStepWait;
`else
  localparam state_e DoneSt = StFetch0;
`endif

  state_e            state_q, state_d;
  state_e            dec_first;
  logic              dec_illegal;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd, rs;
  logic              jump_taken;
  logic              unused_ir;
  strobes_t          so;
  logic [REG_AW-1:0] addr;

  assign op        = bus.ir[WIDTH-1 -: OP_W];
  assign rd        = bus.ir[2*REG_AW-1 -: REG_AW];
  assign rs        = bus.ir[REG_AW-1:0];
  assign unused_ir = ^bus.ir;

  assign jump_taken = (op == OP_JZ) ? bus.zero : ~bus.zero;

  ctrl_decode u_decode (
    .op_i       (op),
    .first_st_o (dec_first),
    .illegal_o  (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StFetch0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch0:   state_d = StFetch1;
      StFetch1:   if (bus.mem_ack) state_d = StFetch2;
      StFetch2:   state_d = StDecode;
      StDecode:   state_d = dec_illegal ? DoneSt : dec_first;
      StA0:       state_d = StA1;
      StA1:       state_d = StA2;
      StA2:       state_d = DoneSt;
      StL0:       state_d = StL1;
      StL1:       if (bus.mem_ack) state_d = StL2;
      StL2:       state_d = DoneSt;
      StS0:       state_d = StS1;
      StS1:       state_d = StS2;
      StS2:       if (bus.mem_ack) state_d = DoneSt;
      StI0:       state_d = StI1;
      StI1:       if (bus.mem_ack) state_d = StI2;
      StI2:       state_d = DoneSt;
      StJ0:       state_d = jump_taken ? StJ1 : DoneSt;
      StJ1:       state_d = DoneSt;
      StHalted:   state_d = StHalted;
`ifdef CTRL_STEP_EN
      StStepWait: if (bus.step) state_d = StFetch0;
`else
      StStepWait: state_d = StFetch0;
`endif
      default:    state_d = StFetch0;
    endcase
  end

  // mdr_ld_mem follows mem_ack so the MDR captures only in the completing cycle.
  always_comb begin
    so   = '0;
    addr = '0;
    unique case (state_q)
      StFetch0, StI0: begin
        so.pc_oe  = 1'b1;
        so.mar_ld = 1'b1;
      end
      StFetch1, StL1, StI1: begin
        so.mem_rd     = 1'b1;
        so.mdr_ld_mem = bus.mem_ack;
      end
      StFetch2: begin
        so.mdr_oe = 1'b1;
        so.ir_ld  = 1'b1;
        so.pc_inc = 1'b1;
      end
      StDecode: so.illegal = dec_illegal;
      StA0: begin
        so.alu_op   = op[ALU_OP_W-1:0];
        addr        = rd;
        so.reg_rd   = 1'b1;
        so.alu_x_ld = 1'b1;
      end
      StA1: begin
        so.alu_op   = op[ALU_OP_W-1:0];
        addr        = rs;
        so.reg_rd   = 1'b1;
        so.alu_y_ld = 1'b1;
      end
      StA2: begin
        so.alu_op = op[ALU_OP_W-1:0];
        so.alu_oe = 1'b1;
        addr      = rd;
        so.reg_wr = 1'b1;
      end
      StL0, StS0: begin
        addr      = rs;
        so.reg_rd = 1'b1;
        so.mar_ld = 1'b1;
      end
      StL2: begin
        so.mdr_oe = 1'b1;
        addr      = rd;
        so.reg_wr = 1'b1;
      end
      StS1: begin
        addr          = rd;
        so.reg_rd     = 1'b1;
        so.mdr_ld_bus = 1'b1;
      end
      StS2: so.mem_wr = 1'b1;
      StI2: begin
        so.mdr_oe = 1'b1;
        addr      = rd;
        so.reg_wr = 1'b1;
        so.pc_inc = 1'b1;
      end
      StJ0: begin
        addr      = rd;
        so.reg_rd = 1'b1;
      end
      StJ1: begin
        addr      = rs;
        so.reg_rd = 1'b1;
        so.pc_ld  = 1'b1;
      end
      StHalted: so.halted = 1'b1;
      default: ;
    endcase
  end

  // Reset gates every output combinationally so pending requests drop immediately.
  strobes_t          so_g;
  logic [REG_AW-1:0] addr_g;

  assign so_g   = reset ? so : '0;
  assign addr_g = reset ? addr : '0;

  assign bus.pc_oe      = so_g.pc_oe;
  assign bus.pc_ld      = so_g.pc_ld;
  assign bus.pc_inc     = so_g.pc_inc;
  assign bus.ir_ld      = so_g.ir_ld;
  assign bus.mar_ld     = so_g.mar_ld;
  assign bus.mdr_ld_bus = so_g.mdr_ld_bus;
  assign bus.mdr_ld_mem = so_g.mdr_ld_mem;
  assign bus.mdr_oe     = so_g.mdr_oe;
  assign bus.mem_rd     = so_g.mem_rd;
  assign bus.mem_wr     = so_g.mem_wr;
  assign bus.alu_op     = so_g.alu_op;
  assign bus.alu_x_ld   = so_g.alu_x_ld;
  assign bus.alu_y_ld   = so_g.alu_y_ld;
  assign bus.alu_oe     = so_g.alu_oe;
  assign bus.reg_addr   = addr_g;
  assign bus.reg_rd     = so_g.reg_rd;
  assign bus.reg_wr     = so_g.reg_wr;
  assign bus.halted     = so_g.halted;
  assign bus.illegal    = so_g.illegal;

endmodule
